gpout_router: RTL and testbench

GPOUT_ROUTER -- requirements
Module: gpout_router

---
 rtl/gpout_router.sv | 127 ++++++++++++
 tb/tb_gpout_router.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpout_router.sv
// Per-channel GPIO output router: synchronised source select with blanking, plus direct/registered/sticky/toggle modes.
// Optional macro GPOUT_ROUTER_CAPTURE_EN compiles in the sticky (2) and toggle (3) modes and i_clear handling.
module gpout_router #(
  parameter int NCH   = 6,
  parameter int SEL_W = 6,
  parameter int DIV_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NCH*SEL_W-1:0]      i_sel,
  input  logic [NCH*2-1:0]          i_mode,
  input  logic [NCH-1:0]            i_primary,
  input  logic [NCH-1:0]            i_alt,
  input  logic [(1<<SEL_W)-1:0]     i_src,
  input  logic                      i_clear,
  output logic [NCH-1:0]            o_gpout,
  output logic [NCH-1:0]            o_sel_busy
);

  localparam int NSRC = 1 << SEL_W;
  localparam logic [SEL_W-1:0] CLK_IDX = SEL_W'(2);

`ifndef GPOUT_ROUTER_CAPTURE_EN
  logic unused_clear;
  assign unused_clear = i_clear;
`endif

  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SEL_W-1:0] s1_reg;
      logic [SEL_W-1:0] s2_reg;
      logic [SEL_W-1:0] applied_reg;
      logic             blank_reg;
      logic             out_reg;
      logic [1:0]       mode;
      logic [NSRC-1:0]  src_vec;
      logic             src_raw;
      logic             samp;
      logic             load;
`ifdef GPOUT_ROUTER_CAPTURE_EN
      logic             prev_reg;
`endif

      assign mode = i_mode[gi*2 +: 2];

      // Low indices are channel-local sources; the rest come from the shared bus.
      always_comb begin
        src_vec    = i_src;
        src_vec[0] = i_primary[gi];
        src_vec[1] = i_alt[gi];
        src_vec[2] = clk;
        for (int j = 0; j < DIV_W; j++) begin
          src_vec[3+j] = div_reg[j];
        end
      end

      assign src_raw = src_vec[applied_reg];
      // The clock itself cannot be sampled by a register clocked on it; treat it as 0.
      assign samp    = (applied_reg != CLK_IDX) && src_raw;
      assign load    = (s1_reg == s2_reg) && (s2_reg != applied_reg);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_reg      <= '0;
          s2_reg      <= '0;
          applied_reg <= '0;
          blank_reg   <= 1'b0;
          out_reg     <= 1'b0;
`ifdef GPOUT_ROUTER_CAPTURE_EN
          prev_reg    <= 1'b0;
`endif
        end else begin
          s1_reg <= i_sel[gi*SEL_W +: SEL_W];
          s2_reg <= s1_reg;
          if (load) begin
            applied_reg <= s2_reg;
            blank_reg   <= 1'b1;
            out_reg     <= 1'b0;
`ifdef GPOUT_ROUTER_CAPTURE_EN
            prev_reg    <= 1'b0;
`endif
          end else begin
            blank_reg <= 1'b0;
`ifdef GPOUT_ROUTER_CAPTURE_EN
            case (mode)
              2'd2: begin
                if (samp) begin
                  out_reg <= 1'b1;
                end else if (i_clear) begin
                  out_reg <= 1'b0;
                end
              end
              2'd3: begin
                if (i_clear) begin
                  out_reg <= 1'b0;
                end else if (samp && !prev_reg) begin
                  out_reg <= ~out_reg;
                end
              end
              default: out_reg <= samp;
            endcase
            // Edge history follows the source in every mode so a switch into toggle mode is seamless.
            prev_reg <= i_clear ? 1'b0 : samp;
`else
            out_reg <= samp;
`endif
          end
        end
      end

      assign o_gpout[gi]    = (mode == 2'd0) ? src_raw : (!blank_reg && out_reg);
      assign o_sel_busy[gi] = (s1_reg != applied_reg) || (s2_reg != applied_reg) || blank_reg;
    end
  endgenerate

endmodule

// File: tb/tb_gpout_router.sv
// Self-checking bench for gpout_router: directed scenarios plus randomized traffic against a behavioural model.
module tb_gpout_router;
  localparam int NCH   = 6;
  localparam int SEL_W = 6;
  localparam int DIV_W = 4;
  localparam int NSRC  = 1 << SEL_W;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCH*SEL_W-1:0] i_sel = '0;
  logic [NCH*2-1:0]     i_mode = '0;
  logic [NCH-1:0]       i_primary = '0;
  logic [NCH-1:0]       i_alt = '0;
  logic [NSRC-1:0]      i_src = '0;
  logic                 i_clear = 1'b0;
  logic [NCH-1:0]       o_gpout;
  logic [NCH-1:0]       o_sel_busy;

  int checks = 0;
  int errors = 0;

  gpout_router #(.NCH(NCH), .SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .i_sel(i_sel), .i_mode(i_mode),
    .i_primary(i_primary), .i_alt(i_alt), .i_src(i_src), .i_clear(i_clear),
    .o_gpout(o_gpout), .o_sel_busy(o_sel_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: last two sampled selects, applied select, blank flag, output and edge history.
  int m_div;
  int m_h1[NCH];
  int m_h2[NCH];
  int m_app[NCH];
  bit m_blank[NCH];
  bit m_out[NCH];
  bit m_prev[NCH];

  function automatic int sel_of(int c);
    return int'(i_sel[c*SEL_W +: SEL_W]);
  endfunction

  function automatic int mode_of(int c);
    return int'(i_mode[c*2 +: 2]);
  endfunction

  function automatic bit src_of(int c, int idx, bit clk_val);
    if (idx == 0) return i_primary[c];
    if (idx == 1) return i_alt[c];
    if (idx == 2) return clk_val;
    if (idx < 3 + DIV_W) return bit'((m_div >> (idx - 3)) & 1);
    return i_src[idx];
  endfunction

  task automatic model_reset();
    m_div = 0;
    for (int c = 0; c < NCH; c++) begin
      m_h1[c] = 0; m_h2[c] = 0; m_app[c] = 0;
      m_blank[c] = 0; m_out[c] = 0; m_prev[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit samp;
      int md;
      samp = src_of(c, m_app[c], 1'b0);
      md   = mode_of(c);
      if (m_h1[c] == m_h2[c] && m_h2[c] != m_app[c]) begin
        m_app[c] = m_h2[c]; m_blank[c] = 1; m_out[c] = 0; m_prev[c] = 0;
      end else begin
        m_blank[c] = 0;
`ifdef GPOUT_ROUTER_CAPTURE_EN
        if (md == 2) begin
          if (samp) m_out[c] = 1; else if (i_clear) m_out[c] = 0;
        end else if (md == 3) begin
          if (i_clear) m_out[c] = 0; else if (samp && !m_prev[c]) m_out[c] = !m_out[c];
        end else begin
          m_out[c] = samp;
        end
        m_prev[c] = i_clear ? 1'b0 : samp;
`else
        m_out[c] = samp;
`endif
      end
      m_h2[c] = m_h1[c];
      m_h1[c] = sel_of(c);
    end
    m_div = (m_div + 1) % (1 << DIV_W);
  endtask

  function automatic logic [NCH-1:0] exp_gpout();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[c] = (mode_of(c) == 0) ? src_of(c, m_app[c], clk) : (!m_blank[c] && m_out[c]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_busy();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[c] = (m_h1[c] != m_app[c]) || (m_h2[c] != m_app[c]) || m_blank[c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #2;
  endtask

  task automatic test_reset();
    i_sel = '0; i_mode = '0; i_primary = 6'b101010; i_alt = 6'b010101; i_src = '1; i_clear = 0;
    reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (o_gpout !== 6'b101010) begin errors++; $display("FAIL reset_gpout: got %b expected %b", o_gpout, 6'b101010); end
    checks++;
    if (o_sel_busy !== 6'b000000) begin errors++; $display("FAIL reset_busy: got %b expected %b", o_sel_busy, 6'b0); end
    i_mode[2*1 +: 2] = 2'd1;
    #1;
    checks++;
    if (o_gpout !== 6'b101000) begin errors++; $display("FAIL reset_mode1_zero: got %b expected %b", o_gpout, 6'b101000); end
    i_mode = '0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1;
    #1;
    checks++;
    if (o_gpout !== 6'b101010) begin errors++; $display("FAIL release_gpout: got %b expected %b", o_gpout, 6'b101010); end
    tick();
    checks++;
    if (o_gpout !== exp_gpout() || o_sel_busy !== 6'b0) begin
      errors++; $display("FAIL post_release: got %b/%b expected %b/%b", o_gpout, o_sel_busy, exp_gpout(), 6'b0);
    end
    $display("test_reset done");
  endtask

  task automatic test_sel_apply();
    int busy_cycles;
    busy_cycles = 0;
    i_mode[0 +: 2] = 2'd1;
    repeat (2) tick();
    i_sel[0 +: SEL_W] = 6'd4;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (o_sel_busy[0]) busy_cycles++;
      checks++;
      if (o_gpout !== exp_gpout() || o_sel_busy !== exp_busy()) begin
        errors++; $display("FAIL sel_apply t=%0d: got %b/%b expected %b/%b", t, o_gpout, o_sel_busy, exp_gpout(), exp_busy());
      end
      if (t == 2) begin
        checks++;
        if (o_gpout[0] !== 1'b0) begin errors++; $display("FAIL sel_apply_blank: got %b expected 0", o_gpout[0]); end
      end
    end
    checks++;
    if (busy_cycles != 3) begin errors++; $display("FAIL sel_apply_busy_len: got %0d expected 3", busy_cycles); end
    $display("test_sel_apply done");
  endtask

  task automatic test_glitch();
    i_sel[1*SEL_W +: SEL_W] = 6'd9;
    tick();
    i_sel[1*SEL_W +: SEL_W] = 6'd0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (o_gpout[1] !== i_primary[1] || o_gpout !== exp_gpout() || o_sel_busy !== exp_busy()) begin
        errors++; $display("FAIL glitch t=%0d: got %b/%b expected %b/%b", t, o_gpout, o_sel_busy, exp_gpout(), exp_busy());
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_sticky();
    bit exp_b;
    i_mode[2*2 +: 2] = 2'd2;
    i_sel[2*SEL_W +: SEL_W] = 6'd20;
    i_src[20] = 0;
    repeat (4) tick();
    i_src[20] = 1; tick();
    checks++;
    if (o_gpout[2] !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b expected 1", o_gpout[2]); end
    i_src[20] = 0; tick();
`ifdef GPOUT_ROUTER_CAPTURE_EN
    exp_b = 1;
`else
    exp_b = 0;
`endif
    checks++;
    if (o_gpout[2] !== exp_b) begin errors++; $display("FAIL sticky_hold: got %b expected %b", o_gpout[2], exp_b); end
    i_src[20] = 1; i_clear = 1; tick();
    checks++;
    if (o_gpout[2] !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b expected 1", o_gpout[2]); end
    i_src[20] = 0; tick();
    i_clear = 0;
    checks++;
    if (o_gpout[2] !== 1'b0 || o_gpout !== exp_gpout()) begin
      errors++; $display("FAIL sticky_clear: got %b expected %b", o_gpout, exp_gpout());
    end
    $display("test_sticky done");
  endtask

  task automatic test_toggle();
    bit exp_b;
    i_mode[3*2 +: 2] = 2'd3;
    i_sel[3*SEL_W +: SEL_W] = 6'd20;
    i_src[20] = 0;
    repeat (4) tick();
    for (int p = 0; p < 5; p++) begin
      i_src[20] = 1; tick();
      checks++;
      if (o_gpout !== exp_gpout()) begin errors++; $display("FAIL toggle_hi p=%0d: got %b expected %b", p, o_gpout, exp_gpout()); end
      i_src[20] = 0; tick();
      checks++;
      if (o_gpout !== exp_gpout()) begin errors++; $display("FAIL toggle_lo p=%0d: got %b expected %b", p, o_gpout, exp_gpout()); end
    end
`ifdef GPOUT_ROUTER_CAPTURE_EN
    exp_b = 1;
`else
    exp_b = 0;
`endif
    checks++;
    if (o_gpout[3] !== exp_b) begin errors++; $display("FAIL toggle_final: got %b expected %b", o_gpout[3], exp_b); end
    $display("test_toggle done");
  endtask

  task automatic test_reset_mid();
    i_mode[4*2 +: 2] = 2'd0;
    i_primary[4] = 1; i_src[7] = 0;
    i_sel[4*SEL_W +: SEL_W] = 6'd7;
    tick();
    reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (o_sel_busy !== 6'b0 || o_gpout[4] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_during: got %b/%b expected busy 0 gpout[4] 1", o_sel_busy, o_gpout);
    end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (o_gpout[4] !== (t < 2 ? 1'b1 : 1'b0) || o_gpout !== exp_gpout() || o_sel_busy !== exp_busy()) begin
        errors++; $display("FAIL reset_mid t=%0d: got %b/%b expected %b/%b", t, o_gpout, o_sel_busy, exp_gpout(), exp_busy());
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(5) == 0) i_sel[c*SEL_W +: SEL_W] = SEL_W'($urandom_range(NSRC - 1));
        if ($urandom_range(19) == 0) i_mode[c*2 +: 2] = 2'($urandom_range(3));
      end
      i_primary = NCH'($urandom);
      i_alt     = NCH'($urandom);
      i_src     = {$urandom, $urandom};
      i_clear   = ($urandom_range(7) == 0);
      tick();
      checks++;
      if (o_gpout !== exp_gpout()) begin
        errors++; bad++; $display("FAIL random_gpout t=%0d: got %b expected %b", t, o_gpout, exp_gpout());
      end
      checks++;
      if (o_sel_busy !== exp_busy()) begin
        errors++; bad++; $display("FAIL random_busy t=%0d: got %b expected %b", t, o_sel_busy, exp_busy());
      end
    end
    i_clear = 0;
    $display("test_random done, %0d mismatching cycles", bad);
  endtask

  initial begin
    test_reset();
    test_sel_apply();
    test_glitch();
    test_sticky();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
